// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Reads words from a FIFO that has a fixed read latency and presents them
//   as a valid/ready stream. A small circular skid buffer absorbs the words
//   that are still in the FIFO read pipeline, so a sink that is always ready
//   receives one word per cycle.
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous, active-high
//   fifo_empty      FIFO empty flag
//   fifo_read       FIFO read strobe, one word per cycle while high
//   fifo_read_data  FIFO read data, valid LATENCY cycles after fifo_read
//   out_valid       stream word available
//   out_ready       sink accepts the word when out_valid & out_ready
//   out_data        stream data (head of the skid buffer)
//   busy            a read is in flight or a word is buffered

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int BUF_DEPTH = LATENCY + 1;
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int TRK_W     = (LATENCY > 0) ? LATENCY : 1;

    localparam logic [3:0]       DEPTH_C  = 4'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    generate
        if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
            $error("fifo_stream_reader: LATENCY must be in 0..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [2**PTR_W];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [3:0]            count;
    logic [3:0]            occ;
    logic [TRK_W-1:0]      in_flight;
    logic                  push;
    logic                  pop;

    function automatic logic [3:0] ones(input logic [TRK_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < TRK_W; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = out_valid | (in_flight != '0);

    // Every issued read owns a buffer slot until it is popped, so occupancy
    // counts words in flight as well as words stored. A pop in the same cycle
    // frees a slot, which keeps full throughput with a ready sink.
    assign occ       = count + ones(in_flight);
    assign fifo_read = !reset && !fifo_empty && ((occ < DEPTH_C) || pop);

    generate
        if (LATENCY == 0) begin : g_lat0
            assign in_flight = '0;
            assign push      = fifo_read;
        end else begin : g_latn
            // Bit LATENCY-1 marks a read whose data is on fifo_read_data now.
            assign push = !reset && in_flight[LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_flight <= '0;
                end else begin
                    in_flight <= TRK_W'({in_flight, fifo_read});
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_read_data;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Three readers (LATENCY 0, 1, 2) each sit behind their own FIFO model;
//   all FIFOs receive the same writes and all readers see the same out_ready.
//   A write log provides the expected word order for every lane.

module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out_ready = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       rst_q = 1'b0;

    logic       rd    [3];
    logic       empty [3];
    logic       ov    [3];
    logic       bsy   [3];
    logic [7:0] rdat  [3];
    logic [7:0] odat  [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int epoch = 0;
    int wlog[$];

    // per-lane bookkeeping, written only by the monitor process
    int rd_pos    [3];
    int reads     [3];
    int pops      [3];
    int rd_pulses [3];
    int first_rd  [3];
    int last_rd   [3];
    int first_val [3];
    int ep_seen   [3];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
        if (!reset && wr_en) wlog.push_back(int'(wr_data));
    end

    for (genvar k = 0; k < 3; k++) begin : g_lane
        logic [7:0] fm [32];
        logic [7:0] pipe [2];
        int cnt = 0;
        int hd = 0;
        int tl = 0;

        assign empty[k] = (cnt == 0);

        always @(posedge clk) begin
            if (reset) begin
                cnt <= 0;
                hd  <= 0;
                tl  <= 0;
            end else begin
                if (wr_en) begin
                    fm[tl] <= wr_data;
                    tl     <= (tl + 1) % 32;
                end
                if (rd[k]) hd <= (hd + 1) % 32;
                cnt <= cnt + (wr_en ? 1 : 0) - (rd[k] ? 1 : 0);
            end
            // read pipeline keeps running through reset: stale data must be ignored
            pipe[0] <= fm[hd];
            pipe[1] <= pipe[0];
        end

        if (k == 0) begin : g_l0
            assign rdat[k] = fm[hd];
        end else begin : g_ln
            assign rdat[k] = pipe[k-1];
        end

        fifo_stream_reader #(.DATA_WIDTH(8), .LATENCY(k)) dut (
            .clk            (clk),
            .reset          (reset),
            .fifo_empty     (empty[k]),
            .fifo_read      (rd[k]),
            .fifo_read_data (rdat[k]),
            .out_valid      (ov[k]),
            .out_ready      (out_ready),
            .out_data       (odat[k]),
            .busy           (bsy[k])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ep_seen[k] != epoch) begin
                ep_seen[k]   = epoch;
                rd_pulses[k] = 0;
                first_rd[k]  = -1;
                last_rd[k]   = -1;
                first_val[k] = -1;
            end
            if (reset) begin
                chk($sformatf("rst_read_L%0d", k), rd[k], 0);
                if (rst_q) begin
                    chk($sformatf("rst_valid_L%0d", k), ov[k], 0);
                    chk($sformatf("rst_data_L%0d", k), odat[k], 0);
                    chk($sformatf("rst_busy_L%0d", k), bsy[k], 0);
                end
                rd_pos[k] = wlog.size();
                reads[k]  = 0;
                pops[k]   = 0;
            end else begin
                if (rd[k]) begin
                    chk($sformatf("read_when_empty_L%0d", k), empty[k], 0);
                    reads[k]++;
                    rd_pulses[k]++;
                    if (first_rd[k] < 0) first_rd[k] = cyc;
                    last_rd[k] = cyc;
                end
                if (ov[k] && first_val[k] < 0) first_val[k] = cyc;
                if (ov[k] && out_ready) begin
                    if (rd_pos[k] < wlog.size())
                        chk($sformatf("data_L%0d", k), odat[k], wlog[rd_pos[k]]);
                    else
                        chk($sformatf("extra_word_L%0d", k), 1, 0);
                    rd_pos[k]++;
                    pops[k]++;
                end
                chk($sformatf("occupancy_L%0d", k), (reads[k] - pops[k]) <= k + 1, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_epoch();
        epoch++;
        step();
    endtask

    task automatic write_range(input int first, input int last, input bit toggle);
        for (int v = first; v <= last; v++) begin
            if (toggle) out_ready = ((v - first) % 2) == 0;
            wr_en   = 1'b1;
            wr_data = 8'(v);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit toggle);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 400) begin
            if (toggle) out_ready = ~out_ready;
            step();
            done = 1'b1;
            for (int k = 0; k < 3; k++)
                if (bsy[k] || !empty[k] || rd_pos[k] != wlog.size()) done = 1'b0;
            n++;
        end
        chk(tag, done, 1);
    endtask

    int start [3];

    task automatic snap();
        for (int k = 0; k < 3; k++) start[k] = rd_pos[k];
    endtask

    task automatic chk_delivered(input string tag, input int n);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_count_L%0d", tag, k), rd_pos[k] - start[k], n);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // 1: reset held, FIFO empty
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_valid_L%0d", k), ov[k], 0);
            chk($sformatf("t1_busy_L%0d", k), bsy[k], 0);
        end

        // 2: 0..31 with a ready sink
        out_ready = 1'b1;
        new_epoch();
        snap();
        write_range(0, 31, 1'b0);
        wait_idle("t2_idle", 1'b0);
        chk_delivered("t2", 32);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_read_pulses_L%0d", k), rd_pulses[k], 32);
            chk($sformatf("t2_read_span_L%0d", k), last_rd[k] - first_rd[k], 31);
            chk($sformatf("t2_first_latency_L%0d", k), first_val[k] - first_rd[k], k + 1);
        end

        // 3: backpressure with 10 words
        out_ready = 1'b0;
        new_epoch();
        snap();
        write_range(0, 9, 1'b0);
        repeat (20) step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_read_pulses_L%0d", k), rd_pulses[k], k + 1);
            chk($sformatf("t3_valid_held_L%0d", k), ov[k], 1);
            chk($sformatf("t3_data_held_L%0d", k), odat[k], 0);
            chk($sformatf("t3_busy_held_L%0d", k), bsy[k], 1);
        end
        out_ready = 1'b1;
        wait_idle("t3_idle", 1'b0);
        chk_delivered("t3", 10);

        // 4: alternating ready, 32..71
        new_epoch();
        snap();
        write_range(32, 71, 1'b1);
        wait_idle("t4_idle", 1'b1);
        chk_delivered("t4", 40);

        // 5: three preloaded words, then write and consume every cycle
        out_ready = 1'b0;
        new_epoch();
        snap();
        write_range(48, 50, 1'b0);
        out_ready = 1'b1;
        write_range(51, 117, 1'b0);
        wait_idle("t5_idle", 1'b0);
        chk_delivered("t5", 70);

        // 6: reset mid-stream, then a fresh stream
        out_ready = 1'b1;
        new_epoch();
        for (int v = 200; v < 210; v++) begin
            wr_en   = 1'b1;
            wr_data = 8'(v);
            step();
        end
        wr_en = 1'b0;
        reset = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_rst_valid_L%0d", k), ov[k], 0);
            chk($sformatf("t6_rst_busy_L%0d", k), bsy[k], 0);
        end
        reset = 1'b0;
        step();
        snap();
        write_range(128, 197, 1'b0);
        wait_idle("t6_idle", 1'b0);
        chk_delivered("t6", 70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
